// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage hazard bus between the decode stage (master) and the forwarding/hazard controller (slave).
// The ID fields are meaningful only while id_valid=1; there is no ready: stall is the back-pressure, same cycle.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic              stall;
  logic [1:0]        ex_fwd_a_sel;
  logic [1:0]        ex_fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_regwrite, id_memread, flush,
    input  stall, ex_fwd_a_sel, ex_fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_regwrite, id_memread, flush,
    output stall, ex_fwd_a_sel, ex_fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX operand-forwarding select generation and load-use stall detection for a 5-stage pipeline.
// Shadows the destination info of the EX and MEM instructions; selects are registered as the ID instruction enters EX.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rstn,
  fwd_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  logic              ex_v_q, ex_v_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_ld_q, ex_ld_d;
  logic              mem_v_q, mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_rw_q, mem_rw_d;
  logic [1:0]        a_sel_q, a_sel_d;
  logic [1:0]        b_sel_q, b_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;
  logic stall_c, bubble;
  logic [1:0] a_next, b_next;

  // x0 is hard-wired zero, so it never matches a producer.
  function automatic logic hit(input logic [REG_AW-1:0] r, input logic v, input logic rw,
                               input logic [REG_AW-1:0] rd);
    return (r != '0) && v && rw && (rd == r);
  endfunction

  always_comb begin
    hit_ex1  = hit(bus.id_rs1, ex_v_q, ex_rw_q, ex_rd_q);
    hit_ex2  = hit(bus.id_rs2, ex_v_q, ex_rw_q, ex_rd_q);
    hit_mem1 = hit(bus.id_rs1, mem_v_q, mem_rw_q, mem_rd_q);
    hit_mem2 = hit(bus.id_rs2, mem_v_q, mem_rw_q, mem_rd_q);

    stall_c = bus.id_valid && !bus.flush && ex_v_q && ex_ld_q &&
              ((bus.id_rs1_used && hit_ex1) || (bus.id_rs2_used && hit_ex2));

    // EX is the youngest producer, so it is checked before MEM.
    a_next = SEL_RF;
    if (bus.id_rs1_used && hit_ex1)       a_next = SEL_EXM;
    else if (bus.id_rs1_used && hit_mem1) a_next = SEL_MWB;
    b_next = SEL_RF;
    if (bus.id_rs2_used && hit_ex2)       b_next = SEL_EXM;
    else if (bus.id_rs2_used && hit_mem2) b_next = SEL_MWB;

    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_rw_d = ex_rw_q;

    bubble  = bus.flush || stall_c || !bus.id_valid;
    ex_v_d  = 1'b0;
    ex_rd_d = '0;
    ex_rw_d = 1'b0;
    ex_ld_d = 1'b0;
    a_sel_d = SEL_RF;
    b_sel_d = SEL_RF;
    if (!bubble) begin
      ex_v_d  = 1'b1;
      ex_rd_d = bus.id_rd;
      ex_rw_d = bus.id_regwrite;
      ex_ld_d = bus.id_memread;
      a_sel_d = a_next;
      b_sel_d = b_next;
    end

    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      a_sel_q  <= SEL_RF;
      b_sel_q  <= SEL_RF;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      a_sel_q  <= a_sel_d;
      b_sel_q  <= b_sel_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.ex_fwd_a_sel = a_sel_q;
  assign bus.ex_fwd_b_sel = b_sel_q;
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a full-width instance plus a 4-bit-counter instance
// sharing the same stimulus, so counter saturation is reachable in a short run.
module tb_fwd_hazard_ctrl;

  localparam int AW    = 5;
  localparam int CW    = 16;
  localparam int CW_S  = 4;
  localparam int SAT_S = (1 << CW_S) - 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW))   bus ();
  fwd_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW_S)) bus_s ();

  assign bus_s.id_valid    = bus.id_valid;
  assign bus_s.id_rs1      = bus.id_rs1;
  assign bus_s.id_rs2      = bus.id_rs2;
  assign bus_s.id_rs1_used = bus.id_rs1_used;
  assign bus_s.id_rs2_used = bus.id_rs2_used;
  assign bus_s.id_rd       = bus.id_rd;
  assign bus_s.id_regwrite = bus.id_regwrite;
  assign bus_s.id_memread  = bus.id_memread;
  assign bus_s.flush       = bus.flush;

  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW))   dut   (.clk(clk), .rstn(rstn), .bus(bus));
  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW_S)) dut_s (.clk(clk), .rstn(rstn), .bus(bus_s));

  typedef struct {
    logic          v;
    logic [AW-1:0] rs1, rs2;
    logic          u1, u2;
    logic [AW-1:0] rd;
    logic          rw, ld, fl;
    logic          es;
    logic [1:0]    ea, eb;
    int            ec;
  } vec_t;

  vec_t vecs[$];
  logic [CW_S-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                              input logic u2, input int rd, input logic rw, input logic ld,
                              input logic fl, input logic es, input logic [1:0] ea,
                              input logic [1:0] eb, input int ec);
    vec_t r;
    r.v = v; r.rs1 = AW'(rs1); r.rs2 = AW'(rs2); r.u1 = u1; r.u2 = u2;
    r.rd = AW'(rd); r.rw = rw; r.ld = ld; r.fl = fl;
    r.es = es; r.ea = ea; r.eb = eb; r.ec = ec;
    return r;
  endfunction

  function automatic vec_t nop(input int ec);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ec);
  endfunction

  task automatic drive(input vec_t t);
    bus.id_valid = t.v; bus.id_rs1 = t.rs1; bus.id_rs2 = t.rs2;
    bus.id_rs1_used = t.u1; bus.id_rs2_used = t.u2; bus.id_rd = t.rd;
    bus.id_regwrite = t.rw; bus.id_memread = t.ld; bus.flush = t.fl;
  endtask

  // Drive on negedge, check stall late in the low phase, check registered outputs after posedge.
  task automatic apply_vec(input vec_t t, input int idx);
    int ecs;
    @(negedge clk);
    drive(t);
    #3;
    check($sformatf("v%0d stall", idx), int'(bus.stall), int'(t.es));
    check($sformatf("v%0d stall_s", idx), int'(bus_s.stall), int'(t.es));
    @(posedge clk);
    #1;
    ecs = (t.ec > SAT_S) ? SAT_S : t.ec;
    check($sformatf("v%0d a_sel", idx), int'(bus.ex_fwd_a_sel), int'(t.ea));
    check($sformatf("v%0d b_sel", idx), int'(bus.ex_fwd_b_sel), int'(t.eb));
    check($sformatf("v%0d cnt", idx), int'(bus.stall_cnt), t.ec);
    check($sformatf("v%0d cnt_s", idx), int'(bus_s.stall_cnt), ecs);
  endtask

  initial begin
    rstn = 1'b0;
    drive(nop(0));
    repeat (2) @(posedge clk);
    #1;
    check("rst stall", int'(bus.stall), 0);
    check("rst a_sel", int'(bus.ex_fwd_a_sel), 0);
    check("rst b_sel", int'(bus.ex_fwd_b_sel), 0);
    check("rst cnt", int'(bus.stall_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;

    //            v rs1 rs2 u1 u2 rd rw ld fl  es  ea     eb     cnt
    // ADD x5 ; ADD x6,x5,x7
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00, 0));
    vecs.push_back(nop(0));
    // ADD x5 ; NOP ; SUB x8,x1,x5
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(nop(0));
    vecs.push_back(mk(1, 1, 5, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(nop(0));
    // LW x5 ; ADD x6,x5,x5 (stalled once, then both operands from MEM/WB)
    vecs.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 2'b10, 2'b10, 1));
    vecs.push_back(nop(1));
    // ADD x0 ; ADD x1,x0,x0 ; NOP ; LW x0 ; ADD x1,x0,x0
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(nop(1));
    vecs.push_back(mk(1, 2, 0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(nop(1));
    // LW x5 ; flushed ADD x6,x5,x0 ; ADD x9,x6,x5 sees no x6 producer, x5 from MEM
    vecs.push_back(mk(1, 3, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 5, 0, 1, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 6, 5, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b10, 1));
    vecs.push_back(nop(1));
    // LW x5 ; LW x5 ; ADD x6,x5,x5 : one stall, newer load forwards via MEM/WB
    vecs.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 2));
    vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 2'b10, 2'b10, 2));
    vecs.push_back(nop(2));
    // ADD x5 ; ADD x5 ; ADD x6,x5,x5 : youngest producer (EX) wins
    vecs.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 2));
    vecs.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00, 2));
    vecs.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b01, 2));
    vecs.push_back(nop(2));
    // LW x5 ; instruction naming x5 in unused source fields
    vecs.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 2));
    vecs.push_back(mk(1, 5, 5, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00, 2));
    vecs.push_back(nop(2));

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Reset asserted in the middle of a load-use stall
    apply_vec(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 2), 100);
    @(negedge clk);
    drive(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, 0));
    #2;
    check("pre-rst stall", int'(bus.stall), 1);
    rstn = 1'b0;
    #1;
    check("mid-rst stall", int'(bus.stall), 0);
    check("mid-rst a_sel", int'(bus.ex_fwd_a_sel), 0);
    check("mid-rst b_sel", int'(bus.ex_fwd_b_sel), 0);
    check("mid-rst cnt", int'(bus.stall_cnt), 0);
    check("mid-rst cnt_s", int'(bus_s.stall_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #2;
    check("post-rst stall", int'(bus.stall), 0);
    @(posedge clk);
    #1;
    check("post-rst a_sel", int'(bus.ex_fwd_a_sel), 0);
    check("post-rst cnt", int'(bus.stall_cnt), 0);
    apply_vec(nop(0), 101);

    // Saturation: 2^CW_S+3 stalls on the narrow counter
    for (int k = 1; k <= SAT_S + 4; k++) exp_q.push_back(CW_S'((k > SAT_S) ? SAT_S : k));
    for (int k = 1; k <= SAT_S + 4; k++) begin
      logic [CW_S-1:0] e;
      apply_vec(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, k - 1), 200 + 2 * k);
      apply_vec(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00, k), 201 + 2 * k);
      e = exp_q.pop_front();
      check($sformatf("sat%0d cnt_s", k), int'(bus_s.stall_cnt), int'(e));
    end
    apply_vec(nop(SAT_S + 4), 300);
    check("sat final cnt_s", int'(bus_s.stall_cnt), SAT_S);
    check("sat final cnt", int'(bus.stall_cnt), SAT_S + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Generates the 2-bit select codes that drive the EX-stage operand muxes (mux3, in0/in1/in2 convention), and detects load-use hazards in the 5-stage pipeline.
- Keeps its own shadow copy of the destination-register info for the instructions in EX and MEM.
- Asserts stall (PC/IF-ID hold) and inserts bubbles so that every consumer gets the correct forwarding select when it enters EX.

Parameters:
- REG_AW, 5, register-index width (32 architectural registers).
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rstn  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_AW  source register 1 of the ID instruction.
- id_rs2  input  REG_AW  source register 2 of the ID instruction.
- id_rs1_used  input  1  instruction actually reads rs1.
- id_rs2_used  input  1  instruction actually reads rs2.
- id_rd  input  REG_AW  destination register of the ID instruction.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- flush  input  1  branch/jump taken in EX; squash the ID instruction.
- stall  output  1  combinational load-use stall; holds PC and IF/ID.
- ex_fwd_a_sel  output  2  registered select for the EX operand-A mux.
- ex_fwd_b_sel  output  2  registered select for the EX operand-B mux.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding (matches mux3):
  - 2'b00: register-file value.
  - 2'b01: EX/MEM ALU result.
  - 2'b10: MEM/WB writeback data.
  - 2'b11: never driven.
- Internal state:
  - EX entry {v, rd, rw, ld}.
  - MEM entry {v, rd, rw}.
  - Both entries reset to all-zero (v=0).
- Reset values: ex_fwd_a_sel=0, ex_fwd_b_sel=0, stall_cnt=0. Reset takes effect immediately on rstn low, including mid-stall. Once reset is released, stall depends only on the new (empty) state.
- hit_ex(r) = (r!=0) & EX.v & EX.rw & (EX.rd==r).
- hit_mem(r) = (r!=0) & MEM.v & MEM.rw & (MEM.rd==r).
- stall = id_valid & ~flush & EX.v & EX.ld & ((id_rs1_used & hit_ex(id_rs1)) | (id_rs2_used & hit_ex(id_rs2))). Purely combinational, same cycle.
- Next select for rs1 (rs2 is identical with id_rs2 / id_rs2_used):
  - 01 if id_rs1_used & hit_ex(id_rs1).
  - else 10 if id_rs1_used & hit_mem(id_rs1).
  - else 00.
  - Youngest producer wins.
- Each posedge (no reset):
  - MEM <= {EX.v, EX.rd, EX.rw}, always; the pipeline never freezes EX->MEM.
  - If flush or stall or ~id_valid: EX <= bubble (v=0) and both sels <= 00.
  - Otherwise: EX <= {1, id_rd, id_regwrite, id_memread} and sels <= the computed next values.
- Flush has priority over stall: no stall is raised for a squashed instruction.
- Register x0 is never forwarded, never stalls, and is never tracked as a hazard.
- Load-use sequence:
  - Cycle N: stall=1 and a bubble enters EX.
  - Cycle N+1: the load is in MEM, the consumer is still in ID, stall=0, and the consumer's select resolves to 10.
  - Exactly one stall cycle per load-use hazard.
- Back-to-back loads feeding the same consumer: one stall only. The newer load drives 10 after the stall, because the older load has left MEM.
- Reg-file write-then-read in the same cycle (WB vs ID) is handled by the register file. This block does not track WB.
- stall_cnt increments by 1 on every posedge where stall=1 and saturates at all-ones (no wrap).

Test Plan:
- ADD x5 in ID then ADD x6,x5,x7 next cycle -> consumer enters EX with ex_fwd_a_sel=01, ex_fwd_b_sel=00, stall never 1.
- ADD x5; NOP; SUB x8,x1,x5 -> sub enters EX with ex_fwd_b_sel=10, ex_fwd_a_sel=00.
- LW x5 then ADD x6,x5,x5 -> stall=1 for exactly one cycle, stall_cnt=1; add enters EX with a_sel=b_sel=10.
- Writes to x0 (ADD x0 then ADD x1,x0,x0), or LW x0 then consumer -> sels 00, stall 0.
- LW x5 in EX, consumer of x5 in ID with flush=1 -> stall=0, EX gets bubble, sels 00, stall_cnt unchanged.
- Drive rstn low during stall, and separately force 2^CNT_W+3 hazard stalls -> after reset all outputs 0 and stall=0; with CNT_W=16 the counter holds at 16'hFFFF.
